udp_tx_framer: RTL and testbench

//  Transmit-side counterpart of the RX parser chain: builds a complete Ethernet II / IPv4 / UDP frame
//  (preamble, SFD, headers, payload, pad, FCS) around a caller-supplied payload and streams it

---
 rtl/udp_tx_framer.sv | 221 ++++++++++++++++++++++
 tb/tb_udp_tx_framer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_framer.sv
// rtl/udp_tx_framer.sv - Ethernet II / IPv4 / UDP transmit framer
// Streams preamble, headers, payload, pad and FCS byte-wise with on-the-fly IPv4 checksum and CRC-32.
module udp_tx_framer #(
  parameter logic [47:0] SRC_MAC    = 48'h00_1A_2B_3C_4D_5E,
  parameter logic [47:0] DEST_MAC   = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [31:0] SRC_IP     = 32'hC0_00_02_92,
  parameter logic [31:0] DEST_IP    = 32'hC0_00_02_01,
  parameter logic [15:0] SRC_PORT   = 16'd5005,
  parameter logic [15:0] DEST_PORT  = 16'd5005,
  parameter logic [7:0]  TTL        = 8'd64,
  parameter int          IFG_CYCLES = 48
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tx_start,
  input  logic [15:0] tx_len,
  input  logic [7:0]  pl_data,
  input  logic        pl_valid,
  output logic        pl_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last,
  output logic        busy,
  output logic        len_err,
  output logic        underrun
);
  typedef enum logic [3:0] {
    S_IDLE, S_CSUM, S_PRE, S_ETH, S_IP, S_UDP, S_PAY, S_PAD, S_FCS, S_IFG
  } state_t;

  state_t      state_q, state_d, nxt_st;
  logic [15:0] cnt_q, cnt_d, nxt_cnt, len_q, len_d, ip_id_q, ip_id_d, csum_q, csum_d;
  logic [31:0] crc_q, crc_d, crc_upd, fcs_word, sum0, sum1, sum2;
  logic [7:0]  tx_data_q, tx_data_d, hdr_byte;
  logic        tx_valid_q, tx_valid_d, tx_last_q, tx_last_d, busy_q, busy_d;
  logic        bad_fcs_q, bad_fcs_d, len_err_q, len_err_d, underrun_q, underrun_d;
  logic        xfer, len_ok, ifg_done;
  logic [15:0] tot_len, udp_len;
  logic [111:0] eth_hdr;
  logic [159:0] ip_hdr;
  logic [63:0]  udp_hdr;
  logic [6:0]   eth_bit;
  logic [7:0]   ip_bit;
  logic [5:0]   udp_bit;
  logic [4:0]   fcs_bit;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  assign xfer     = tx_valid_q & tx_ready;
  assign len_ok   = (tx_len != 16'd0) && (tx_len <= 16'd1472);
  assign ifg_done = (cnt_q == 16'(IFG_CYCLES - 1));
  assign tot_len  = len_q + 16'd28;
  assign udp_len  = len_q + 16'd8;

  // 32-bit accumulator folded twice covers every possible carry out of ten 16-bit words
  assign sum0 = 32'h4500 + 32'(tot_len) + 32'(ip_id_q) + 32'h4000 + 32'({TTL, 8'h11})
              + 32'(SRC_IP[31:16]) + 32'(SRC_IP[15:0]) + 32'(DEST_IP[31:16]) + 32'(DEST_IP[15:0]);
  assign sum1 = 32'(sum0[15:0]) + 32'(sum0[31:16]);
  assign sum2 = 32'(sum1[15:0]) + 32'(sum1[31:16]);

  assign eth_hdr = {DEST_MAC, SRC_MAC, 16'h0800};
  assign ip_hdr  = {8'h45, 8'h00, tot_len, ip_id_q, 16'h4000, TTL, 8'h11, csum_q, SRC_IP, DEST_IP};
  assign udp_hdr = {SRC_PORT, DEST_PORT, udp_len, 16'h0000};
  assign eth_bit = 7'({16'd13 - nxt_cnt, 3'b000});
  assign ip_bit  = 8'({16'd19 - nxt_cnt, 3'b000});
  assign udp_bit = 6'({16'd7 - nxt_cnt, 3'b000});
  assign fcs_bit = 5'({nxt_cnt, 3'b000});

  assign crc_upd  = crc_byte(crc_q, tx_data_q);
  // FCS byte 0 is loaded on the same edge that folds the final data byte into the CRC
  assign fcs_word = (state_q == S_FCS) ? crc_q : crc_upd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      ip_id_q    <= '0;
      csum_q     <= '0;
      crc_q      <= 32'hFFFF_FFFF;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
      busy_q     <= 1'b0;
      bad_fcs_q  <= 1'b0;
      len_err_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      ip_id_q    <= ip_id_d;
      csum_q     <= csum_d;
      crc_q      <= crc_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      tx_last_q  <= tx_last_d;
      busy_q     <= busy_d;
      bad_fcs_q  <= bad_fcs_d;
      len_err_q  <= len_err_d;
      underrun_q <= underrun_d;
    end
  end

  // Position of the byte following the one currently held in tx_data_q
  always_comb begin
    nxt_st  = state_q;
    nxt_cnt = cnt_q + 16'd1;
    case (state_q)
      S_PRE: if (cnt_q == 16'd7)  begin nxt_st = S_ETH; nxt_cnt = '0; end
      S_ETH: if (cnt_q == 16'd13) begin nxt_st = S_IP;  nxt_cnt = '0; end
      S_IP:  if (cnt_q == 16'd19) begin nxt_st = S_UDP; nxt_cnt = '0; end
      S_UDP: if (cnt_q == 16'd7)  begin nxt_st = S_PAY; nxt_cnt = '0; end
      S_PAY: if (cnt_q == len_q - 16'd1) begin
        nxt_st  = (len_q < 16'd18) ? S_PAD : S_FCS;
        nxt_cnt = '0;
      end
      S_PAD: if (cnt_q == 16'd17 - len_q) begin nxt_st = S_FCS; nxt_cnt = '0; end
      S_FCS: if (cnt_q == 16'd3)  begin nxt_st = S_IFG; nxt_cnt = '0; end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (tx_start && len_ok) begin state_d = S_CSUM; cnt_d = '0; end
      S_CSUM: begin state_d = S_PRE; cnt_d = '0; end
      S_IFG: begin
        if (ifg_done) begin state_d = S_IDLE; cnt_d = '0; end
        else cnt_d = cnt_q + 16'd1;
      end
      default: if (xfer) begin state_d = nxt_st; cnt_d = nxt_cnt; end
    endcase
  end

  always_comb begin
    hdr_byte = 8'h00;
    case (nxt_st)
      S_PRE:   hdr_byte = (nxt_cnt == 16'd7) ? 8'hD5 : 8'h55;
      S_ETH:   hdr_byte = eth_hdr[eth_bit +: 8];
      S_IP:    hdr_byte = ip_hdr[ip_bit +: 8];
      S_UDP:   hdr_byte = udp_hdr[udp_bit +: 8];
      default: hdr_byte = 8'h00;
    endcase
  end

  always_comb begin
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    tx_last_d  = tx_last_q;
    busy_d     = busy_q;
    len_d      = len_q;
    ip_id_d    = ip_id_q;
    csum_d     = csum_q;
    crc_d      = crc_q;
    bad_fcs_d  = bad_fcs_q;
    len_err_d  = 1'b0;
    underrun_d = 1'b0;
    pl_ready   = 1'b0;
    case (state_q)
      S_IDLE: begin
        crc_d     = 32'hFFFF_FFFF;
        bad_fcs_d = 1'b0;
        if (tx_start) begin
          if (len_ok) begin
            len_d  = tx_len;
            busy_d = 1'b1;
          end else begin
            len_err_d = 1'b1;
          end
        end
      end
      S_CSUM: begin
        csum_d     = ~sum2[15:0];
        tx_data_d  = 8'h55;
        tx_valid_d = 1'b1;
      end
      S_IFG: if (ifg_done) busy_d = 1'b0;
      default: if (xfer) begin
        if (state_q inside {S_ETH, S_IP, S_UDP, S_PAY, S_PAD}) crc_d = crc_upd;
        tx_last_d = (nxt_st == S_FCS) && (nxt_cnt == 16'd3);
        case (nxt_st)
          S_PAY: begin
            pl_ready = 1'b1;
            if (pl_valid) begin
              tx_data_d = pl_data;
            end else begin
              tx_data_d  = 8'h00;
              underrun_d = 1'b1;
              bad_fcs_d  = 1'b1;
            end
          end
          S_PAD: tx_data_d = 8'h00;
          // a starved frame gets the complement of its FCS so the receiver is sure to drop it
          S_FCS: tx_data_d = bad_fcs_q ? fcs_word[fcs_bit +: 8] : ~fcs_word[fcs_bit +: 8];
          S_IFG: begin
            tx_data_d  = 8'h00;
            tx_valid_d = 1'b0;
            ip_id_d    = ip_id_q + 16'd1;
          end
          default: tx_data_d = hdr_byte;
        endcase
      end
    endcase
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign tx_last  = tx_last_q;
  assign busy     = busy_q;
  assign len_err  = len_err_q;
  assign underrun = underrun_q;
endmodule

// File: tb/tb_udp_tx_framer.sv
// tb/tb_udp_tx_framer.sv - scoreboard bench for udp_tx_framer
// Stimulus pushes expected frame bytes; a negedge monitor pops and compares every transferred byte.
module tb_udp_tx_framer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tx_start = 1'b0;
  logic [15:0] tx_len = '0;
  logic [7:0]  pl_data = '0;
  logic        pl_valid = 1'b0;
  logic        pl_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        tx_last;
  logic        busy;
  logic        len_err;
  logic        underrun;

  always #10 clk = ~clk;

  udp_tx_framer #(
    .SRC_IP  (32'hC0A8_0001),
    .DEST_IP (32'hC0A8_00C7),
    .TTL     (8'h40)
  ) dut (
    .clk(clk), .reset(reset), .tx_start(tx_start), .tx_len(tx_len),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
    .busy(busy), .len_err(len_err), .underrun(underrun)
  );

  int n_checks = 0;
  int n_err = 0;

  logic [8:0]  exp_q[$];
  int          info_len_q[$];
  bit          info_good_q[$];

  int          cyc = 0, frames = 0, fbytes = 0;
  logic [31:0] rcrc = 32'hFFFF_FFFF;
  int          frame_len[8], fstart[8], fend[8];
  logic [7:0]  cap[5][200];
  int          len_err_cnt = 0, underrun_cnt = 0;

  int          pl_idx = 0, pl_len = 0, drop_idx = -1;
  logic [7:0]  pl_base = '0;
  bit          pl_restart = 1'b0, stall_en = 1'b0, slot;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    bit fb;
    r = c;
    for (int k = 0; k < 8; k++) begin
      fb = r[0] ^ d[k];
      r  = {1'b0, r[31:1]};
      if (fb) r = r ^ 32'hEDB8_8320;
    end
    return r;
  endfunction

  function automatic logic [7:0] pl_byte(input logic [7:0] base, input int i);
    return 8'(int'(base) + i * 13);
  endfunction

  task automatic push_frame(input int len, input int id, input logic [7:0] base, input int drop_i);
    logic [7:0]  body[$];
    logic [7:0]  smac[6] = '{8'h00, 8'h1A, 8'h2B, 8'h3C, 8'h4D, 8'h5E};
    logic [7:0]  ipa[8]  = '{8'hC0, 8'hA8, 8'h00, 8'h01, 8'hC0, 8'hA8, 8'h00, 8'hC7};
    logic [15:0] tl, ul, cs, id16;
    logic [31:0] sum, c, fcs;
    tl = 16'(len + 28);
    ul = 16'(len + 8);
    id16 = 16'(id);
    sum = 32'h4500 + 32'(tl) + 32'(id16) + 32'h4000 + 32'h4011 + 32'hC0A8 + 32'h0001 + 32'hC0A8 + 32'h00C7;
    sum = (sum & 32'hFFFF) + (sum >> 16);
    sum = (sum & 32'hFFFF) + (sum >> 16);
    cs = ~sum[15:0];
    for (int i = 0; i < 6; i++) body.push_back(8'hFF);
    for (int i = 0; i < 6; i++) body.push_back(smac[i]);
    body.push_back(8'h08); body.push_back(8'h00);
    body.push_back(8'h45); body.push_back(8'h00); body.push_back(tl[15:8]); body.push_back(tl[7:0]);
    body.push_back(id16[15:8]); body.push_back(id16[7:0]); body.push_back(8'h40); body.push_back(8'h00);
    body.push_back(8'h40); body.push_back(8'h11); body.push_back(cs[15:8]); body.push_back(cs[7:0]);
    for (int i = 0; i < 8; i++) body.push_back(ipa[i]);
    body.push_back(8'h13); body.push_back(8'h8D); body.push_back(8'h13); body.push_back(8'h8D);
    body.push_back(ul[15:8]); body.push_back(ul[7:0]); body.push_back(8'h00); body.push_back(8'h00);
    for (int i = 0; i < len; i++) body.push_back((i == drop_i) ? 8'h00 : pl_byte(base, i));
    for (int i = len; i < 18; i++) body.push_back(8'h00);
    c = 32'hFFFF_FFFF;
    foreach (body[i]) c = crc_step(c, body[i]);
    fcs = (drop_i >= 0) ? c : ~c;
    for (int i = 0; i < 7; i++) exp_q.push_back({1'b0, 8'h55});
    exp_q.push_back({1'b0, 8'hD5});
    foreach (body[i]) exp_q.push_back({1'b0, body[i]});
    exp_q.push_back({1'b0, fcs[7:0]});
    exp_q.push_back({1'b0, fcs[15:8]});
    exp_q.push_back({1'b0, fcs[23:16]});
    exp_q.push_back({1'b1, fcs[31:24]});
    info_len_q.push_back(8 + body.size() + 4);
    info_good_q.push_back(drop_i < 0);
  endtask

  // monitor / scoreboard
  logic [8:0] e_m;
  int         il_m;
  bit         ig_m;
  always @(negedge clk) begin
    cyc++;
    if (len_err) len_err_cnt++;
    if (underrun) underrun_cnt++;
    if (tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        chk(1'b0, "unexpected_byte", {23'h0, tx_last, tx_data}, 32'h0);
      end else begin
        e_m = exp_q.pop_front();
        chk({tx_last, tx_data} == e_m, "byte", {23'h0, tx_last, tx_data}, {23'h0, e_m});
      end
      if (fbytes == 0 && frames < 8) fstart[frames] = cyc;
      if (frames < 5 && fbytes < 200) cap[frames][fbytes] = tx_data;
      if (fbytes >= 8) rcrc = crc_step(rcrc, tx_data);
      fbytes++;
      if (tx_last) begin
        if (info_len_q.size() == 0) begin
          chk(1'b0, "unexpected_frame", fbytes, 0);
        end else begin
          il_m = info_len_q.pop_front();
          ig_m = info_good_q.pop_front();
          chk(fbytes == il_m, "frame_len", fbytes, il_m);
          chk((rcrc == 32'hDEBB_20E3) == ig_m, "fcs_residue", rcrc, {31'h0, ig_m});
        end
        if (frames < 8) begin frame_len[frames] = fbytes; fend[frames] = cyc; end
        frames++;
        fbytes = 0;
        rcrc = 32'hFFFF_FFFF;
      end
    end
  end

  // payload source and tx_ready driver
  initial begin
    forever begin
      @(negedge clk);
      slot = pl_ready;
      @(posedge clk); #2;
      if (pl_restart) begin
        pl_idx = 0;
        pl_restart = 1'b0;
      end else if (slot) begin
        pl_idx++;
        if (pl_idx == pl_len) pl_idx = 0;
      end
      pl_valid = (pl_idx != drop_idx);
      pl_data  = pl_byte(pl_base, pl_idx);
      tx_ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pl_cfg(input int len, input logic [7:0] base, input int drop_i);
    pl_len = len; pl_base = base; drop_idx = drop_i; pl_restart = 1'b1;
  endtask

  task automatic wait_frames(input int n);
    int k = 0;
    while (frames < n && k < 6000) begin @(negedge clk); k++; end
    chk(frames >= n, "frame_timeout", frames, n);
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (busy && k < 2000) begin @(negedge clk); k++; end
    chk(!busy, "idle_timeout", busy, 0);
  endtask

  task automatic send(input int len);
    tick(); tx_start = 1'b1; tx_len = 16'(len);
    tick(); tx_start = 1'b0;
  endtask

  int base_le, base_ur, k;
  bit quiet;

  initial begin
    #1;
    chk({tx_valid, tx_last, busy, len_err, underrun, pl_ready, tx_data} == '0, "reset_outputs",
        {tx_valid, tx_last, busy, len_err, underrun, pl_ready, tx_data}, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // frame 0 (len 87, id 0) and back-to-back frame 1 (id 1)
    pl_cfg(87, 8'h21, -1);
    push_frame(87, 0, 8'h21, -1);
    push_frame(87, 1, 8'h21, -1);
    tx_len = 16'd87; tx_start = 1'b1;
    wait_frames(1);
    k = 0;
    while (busy && k < 200) begin @(negedge clk); k++; end
    chk(!busy, "b2b_busy_low", busy, 0);
    tick(); tx_start = 1'b0;
    wait_frames(2);
    wait_idle();
    chk(frame_len[0] == 141, "f0_total", frame_len[0], 141);
    chk({cap[0][22], cap[0][23], cap[0][24], cap[0][25]} == 32'h4500_0073, "f0_ip_w0", {cap[0][22], cap[0][23], cap[0][24], cap[0][25]}, 32'h4500_0073);
    chk({cap[0][26], cap[0][27], cap[0][28], cap[0][29]} == 32'h0000_4000, "f0_ip_w1", {cap[0][26], cap[0][27], cap[0][28], cap[0][29]}, 32'h0000_4000);
    chk({cap[0][30], cap[0][31], cap[0][32], cap[0][33]} == 32'h4011_B861, "f0_ip_w2", {cap[0][30], cap[0][31], cap[0][32], cap[0][33]}, 32'h4011_B861);
    chk({cap[0][46], cap[0][47]} == 16'h005F, "f0_udp_len", {cap[0][46], cap[0][47]}, 16'h005F);
    chk({cap[1][26], cap[1][27]} == 16'h0001, "f1_ip_id", {cap[1][26], cap[1][27]}, 16'h0001);
    chk({cap[1][32], cap[1][33]} == 16'hB860, "f1_csum", {cap[1][32], cap[1][33]}, 16'hB860);
    chk(fstart[1] - fend[0] - 1 >= 48, "ifg_gap", fstart[1] - fend[0] - 1, 48);

    // minimum payload: 17 pad bytes
    pl_cfg(1, 8'h5A, -1);
    push_frame(1, 2, 8'h5A, -1);
    send(1);
    wait_frames(3);
    wait_idle();
    chk(frame_len[2] == 72, "f2_total", frame_len[2], 72);

    // illegal lengths
    chk(len_err_cnt == 0, "no_len_err_yet", len_err_cnt, 0);
    base_le = len_err_cnt;
    tick(); tx_start = 1'b1; tx_len = 16'd0;
    tick(); tx_len = 16'd1473;
    tick(); tx_start = 1'b0;
    quiet = 1'b1;
    repeat (6) begin @(negedge clk); if (busy || tx_valid) quiet = 1'b0; end
    chk(quiet, "len_err_quiet", {busy, tx_valid}, 0);
    chk(len_err_cnt - base_le == 2, "len_err_pulses", len_err_cnt - base_le, 2);

    // payload starvation on byte 5
    base_ur = underrun_cnt;
    pl_cfg(30, 8'h77, 4);
    push_frame(30, 3, 8'h77, 4);
    send(30);
    wait_frames(4);
    wait_idle();
    chk(underrun_cnt - base_ur == 1, "underrun_pulses", underrun_cnt - base_ur, 1);
    chk(frame_len[3] == 84, "f3_total", frame_len[3], 84);

    // stalls with reset mid-payload, then a clean frame
    stall_en = 1'b1;
    pl_cfg(40, 8'h10, -1);
    push_frame(40, 4, 8'h10, -1);
    send(40);
    k = 0;
    while (pl_idx < 10 && k < 3000) begin @(negedge clk); k++; end
    chk(pl_idx >= 10, "payload_reach", pl_idx, 10);
    tick();
    reset = 1'b1;
    exp_q.delete(); info_len_q.delete(); info_good_q.delete();
    fbytes = 0; rcrc = 32'hFFFF_FFFF;
    pl_cfg(20, 8'h99, -1);
    #1;
    chk({tx_valid, tx_last, busy, tx_data} == '0, "midframe_reset", {tx_valid, tx_last, busy, tx_data}, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    push_frame(20, 0, 8'h99, -1);
    send(20);
    wait_frames(5);
    wait_idle();
    chk(frame_len[4] == 74, "f4_total", frame_len[4], 74);
    chk({cap[4][26], cap[4][27]} == 16'h0000, "f4_ip_id", {cap[4][26], cap[4][27]}, 16'h0000);
    chk(exp_q.size() == 0, "leftover_bytes", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
